decoder_scan_nxm: RTL and testbench

- Parametrised, registered one-hot decoder with active-low outputs, the N-to-2^N successor of the 2-to-4 enable decoder.
- Two modes: direct (registered decode of `sel_in`) and auto-scan (built-in prescaler steps through all outputs cyclically).
- Drives multiplexed 7-segment digit commons and LED column strobes on the board.

---
 rtl/decoder_scan_nxm_pkg.sv | 23 ++
 rtl/decoder_scan_nxm_if.sv | 27 ++
 rtl/decoder_scan_nxm_prescaler.sv | 30 +++
 rtl/decoder_scan_nxm.sv | 80 ++++++++
 tb/tb_decoder_scan_nxm.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_scan_nxm_pkg.sv
// Shared types and helpers for the registered N-to-2^N scan decoder.
// Decoder widths up to MAX_SEL_W select bits are supported by onehot_n.
package decoder_pkg;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN,
    BLANK
  } state_t;

  // Active-low one-hot at full width; callers truncate to their own OUT_W.
  function automatic logic [MAX_OUT_W-1:0] onehot_n(input logic [MAX_SEL_W-1:0] sel);
    return ~(MAX_OUT_W'(1) << sel);
  endfunction

endpackage

// File: rtl/decoder_scan_nxm_if.sv
// Control and output bundle of decoder_scan_nxm; master drives the controls,
// slave (the decoder) drives the registered outputs.
interface decoder_scan_nxm_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DIV_W = 16
);
  localparam int unsigned OUT_W = 1 << SEL_W;

  logic             enable;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic [DIV_W-1:0] div_val;
  logic [OUT_W-1:0] out_n;
  logic [SEL_W-1:0] cur_sel;
  logic             wrap;

  modport master (
    output enable, mode, sel_in, div_val,
    input  out_n, cur_sel, wrap
  );

  modport slave (
    input  enable, mode, sel_in, div_val,
    output out_n, cur_sel, wrap
  );

endinterface

// File: rtl/decoder_scan_nxm_prescaler.sv
// Dwell prescaler for the scan decoder: counts while enabled and ticks once
// the count reaches the live div_val.
module scan_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // >= rather than == so lowering div_val below the count cannot lock up.
  always_comb begin
    tick = !clr && (count >= div_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/decoder_scan_nxm.sv
// Registered one-hot active-low decoder with direct and auto-scan modes.
// Define DECODER_SCAN_BLANK_EN to insert a blank cycle on every scan advance.
module decoder_scan_nxm
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DIV_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  decoder_scan_nxm_if.slave bus
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  state_t           state;
  logic [OUT_W-1:0] out_n_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic [SEL_W-1:0] sel_next;
  logic             wrap_q;
  logic             scan_run;
  logic             tick;

  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] s);
    return OUT_W'(onehot_n(MAX_SEL_W'(s)));
  endfunction

  // The prescaler only runs while already in SCAN and staying there, so any
  // entry into SCAN (including return from BLANK) starts a fresh dwell.
  always_comb begin
    scan_run = bus.enable && (bus.mode == MODE_SCAN) && (state == SCAN);
    sel_next = cur_sel_q + SEL_W'(1);
  end

  scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!scan_run),
    .div_val (bus.div_val),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_n_q   <= '1;
      cur_sel_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!bus.enable) begin
        state   <= IDLE;
        out_n_q <= '1;
      end else if (bus.mode == MODE_DIRECT) begin
        state     <= DIRECT;
        cur_sel_q <= bus.sel_in;
        out_n_q   <= dec(bus.sel_in);
      end else if (tick) begin
        cur_sel_q <= sel_next;
        wrap_q    <= (cur_sel_q == SEL_W'(OUT_W - 1));
`ifdef DECODER_SCAN_BLANK_EN
        state     <= BLANK;
        out_n_q   <= '1;
`else
        state     <= SCAN;
        out_n_q   <= dec(sel_next);
`endif
      end else begin
        // Entry from IDLE/DIRECT/BLANK or a dwell cycle: show the held channel.
        state   <= SCAN;
        out_n_q <= dec(cur_sel_q);
      end
    end
  end

  assign bus.out_n   = out_n_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nxm.sv
// Randomized bench for decoder_scan_nxm at SEL_W=2 and SEL_W=3 against a
// dwell-counting reference model.
module tb_decoder_scan_nxm;

  localparam int unsigned DIV_W = 16;
`ifdef DECODER_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  decoder_scan_nxm_if #(.SEL_W(2), .DIV_W(DIV_W)) bus2 ();
  decoder_scan_nxm_if #(.SEL_W(3), .DIV_W(DIV_W)) bus3 ();

  decoder_scan_nxm #(.SEL_W(2), .DIV_W(DIV_W)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  decoder_scan_nxm #(.SEL_W(3), .DIV_W(DIV_W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  always #5 clk = ~clk;

  // Reference model: channel index, cycles the channel has been shown so far.
  int nch[2] = '{4, 8};
  int m_sel[2];
  int m_shown[2];
  int m_out[2];
  int m_wrap[2];
  bit m_scan[2];
  bit m_blank[2];

  function automatic int all_off(int n);
    return (1 << n) - 1;
  endfunction

  function automatic int lit(int n, int ch);
    return all_off(n) & ~(1 << ch);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i]   = 0;
      m_shown[i] = 0;
      m_out[i]   = all_off(nch[i]);
      m_wrap[i]  = 0;
      m_scan[i]  = 1'b0;
      m_blank[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit en, input bit md, input int sel, input int dv);
    m_wrap[i] = 0;
    if (!en) begin
      m_scan[i]  = 1'b0;
      m_blank[i] = 1'b0;
      m_out[i]   = all_off(nch[i]);
    end else if (!md) begin
      m_scan[i]  = 1'b0;
      m_blank[i] = 1'b0;
      m_sel[i]   = sel;
      m_out[i]   = lit(nch[i], sel);
    end else if (!m_scan[i] || m_blank[i]) begin
      m_scan[i]  = 1'b1;
      m_blank[i] = 1'b0;
      m_shown[i] = 1;
      m_out[i]   = lit(nch[i], m_sel[i]);
    end else if (m_shown[i] > dv) begin
      m_wrap[i]  = (m_sel[i] == nch[i] - 1) ? 1 : 0;
      m_sel[i]   = (m_sel[i] + 1) % nch[i];
      m_shown[i] = 1;
      if (BLANK_EN) begin
        m_blank[i] = 1'b1;
        m_out[i]   = all_off(nch[i]);
      end else begin
        m_out[i] = lit(nch[i], m_sel[i]);
      end
    end else begin
      m_shown[i]++;
    end
  endtask

  task automatic compare();
    chk("out_n4",   32'(bus2.out_n),   m_out[0]);
    chk("cur_sel4", 32'(bus2.cur_sel), m_sel[0]);
    chk("wrap4",    32'(bus2.wrap),    m_wrap[0]);
    chk("onehot4",  32'($countones(~bus2.out_n) <= 1), 1);
    chk("out_n8",   32'(bus3.out_n),   m_out[1]);
    chk("cur_sel8", 32'(bus3.cur_sel), m_sel[1]);
    chk("wrap8",    32'(bus3.wrap),    m_wrap[1]);
    chk("onehot8",  32'($countones(~bus3.out_n) <= 1), 1);
  endtask

  task automatic drive(input bit en, input bit md, input int s2, input int s3, input int dv);
    bus2.enable  = en;
    bus2.mode    = md;
    bus2.sel_in  = 2'(s2);
    bus2.div_val = 16'(dv);
    bus3.enable  = en;
    bus3.mode    = md;
    bus3.sel_in  = 3'(s3);
    bus3.div_val = 16'(dv);
  endtask

  // One clock: drive at clock-low, advance the model, check at next negedge.
  task automatic cyc(input bit en, input bit md, input int s2, input int s3, input int dv);
    drive(en, md, s2, s3, dv);
    model_step(0, en, md, s2 & 3, dv);
    model_step(1, en, md, s3 & 7, dv);
    @(negedge clk);
    compare();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out4"}, 32'(bus2.out_n), 32'hf);
    chk({tag, "_sel4"}, 32'(bus2.cur_sel), 0);
    chk({tag, "_wrap4"}, 32'(bus2.wrap), 0);
    chk({tag, "_out8"}, 32'(bus3.out_n), 32'hff);
    chk({tag, "_sel8"}, 32'(bus3.cur_sel), 0);
  endtask

  int dir_exp[4] = '{32'he, 32'hd, 32'hb, 32'h7};

  initial begin
    bit en;
    bit md;
    int dv;
    int s2;
    int s3;
    int len;

    drive(1'b1, 1'b1, 1, 5, 0);
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
      #1;
      chk_reset_outputs("reset");
    end
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, 1'b0, s, s, 0);
      chk("direct", 32'(bus2.out_n), dir_exp[s]);
    end
    cyc(1'b0, 1'b0, 3, 3, 0);
    chk("disable", 32'(bus2.out_n), 32'hf);

    cyc(1'b1, 1'b0, 0, 0, 2);
    for (int k = 0; k < 24; k++) cyc(1'b1, 1'b1, 0, 0, 2);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 0, 0, 0);

    cyc(1'b1, 1'b0, 1, 1, 9);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1, 1, 9);
    cyc(1'b1, 1'b1, 1, 1, 1);
    chk("div_drop", 32'(bus2.cur_sel), 2);

    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 1, 1, 2);
      chk("idle_hold", 32'(bus2.out_n), 32'hf);
    end
    cyc(1'b1, 1'b1, 1, 1, 2);
    chk("resume4", 32'(bus2.out_n), 32'hb);
    chk("resume8", 32'(bus3.out_n), 32'hfb);
    cyc(1'b1, 1'b1, 1, 1, 2);
    cyc(1'b1, 1'b0, 0, 0, 2);
    chk("to_direct", 32'(bus2.out_n), 32'he);

    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 0, 0, 1);

    for (int r = 0; r < 120; r++) begin
      en  = ($urandom_range(0, 9) != 0);
      md  = ($urandom_range(0, 9) < 7);
      dv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
      s2  = $urandom_range(0, 3);
      s3  = $urandom_range(0, 7);
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          s2 = $urandom_range(0, 3);
          s3 = $urandom_range(0, 7);
        end
        if ($urandom_range(0, 15) == 0) dv = $urandom_range(0, 6);
        cyc(en, md, s2, s3, dv);
      end
    end

    // Asynchronous reset asserted while the clock is low.
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("areset");
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
